// File: rtl/prf_read_arbiter_if.sv
// prf_read_arbiter_if: requester/bank bundle; master drives requests and bank_busy, slave (arbiter) drives ready and bank reads
interface prf_read_arbiter_if #(
  parameter int PR_COUNT = 128,
  parameter int LOG_PR_COUNT = $clog2(PR_COUNT),
  parameter int PRF_BANK_COUNT = 4,
  parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  parameter int PRF_RR_COUNT = 11,
  parameter int LOG_PRF_RR_COUNT = $clog2(PRF_RR_COUNT)
);
  logic [PRF_RR_COUNT-1:0] req_valid;
  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0] req_PR;
  logic [PRF_RR_COUNT-1:0] req_ready;
  logic [PRF_BANK_COUNT-1:0] bank_busy;
  logic [PRF_BANK_COUNT-1:0] prf_bank_read_valid;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] prf_bank_read_upper_PR;
  logic [PRF_BANK_COUNT-1:0][LOG_PRF_RR_COUNT-1:0] prf_bank_read_req_idx;
  modport master (
    output req_valid, req_PR, bank_busy,
    input req_ready, prf_bank_read_valid, prf_bank_read_upper_PR, prf_bank_read_req_idx
  );
  modport slave (
    input req_valid, req_PR, bank_busy,
    output req_ready, prf_bank_read_valid, prf_bank_read_upper_PR, prf_bank_read_req_idx
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: per-bank round-robin grant of PRF read requesters (CLK, async RST, bus: requests in / combinational ready / registered bank reads out)
module prf_read_arbiter #(
  parameter int PR_COUNT = 128,
  parameter int LOG_PR_COUNT = $clog2(PR_COUNT),
  parameter int PRF_BANK_COUNT = 4,
  parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  parameter int PRF_RR_COUNT = 11,
  parameter int LOG_PRF_RR_COUNT = $clog2(PRF_RR_COUNT)
) (
  input logic CLK,
  input logic RST,
  prf_read_arbiter_if.slave bus
);
  localparam int RR = PRF_RR_COUNT;
  localparam int BC = PRF_BANK_COUNT;
  localparam int LB = LOG_PRF_BANK_COUNT;
  localparam int LRR = LOG_PRF_RR_COUNT;
  localparam int LPR = LOG_PR_COUNT;
  logic [LRR-1:0] rr_ptr [BC];
  logic [BC-1:0] gnt;
  logic [LRR-1:0] win [BC];
  // k-th slot after pointer p, wrapping mod RR; an out-of-range pointer acts as 0
  function automatic logic [LRR-1:0] slot(input logic [LRR-1:0] p, input int k);
    int s;
    s = (int'(p) >= RR ? 0 : int'(p)) + k;
    return LRR'(s >= RR ? s - RR : s);
  endfunction
  // scan from farthest to nearest so the nearest eligible requester is the last write
  always_comb begin
    gnt = '0;
    for (int b = 0; b < BC; b++) begin
      win[b] = '0;
      for (int k = RR - 1; k >= 0; k--)
        if (!bus.bank_busy[b] && bus.req_valid[slot(rr_ptr[b], k)] &&
            bus.req_PR[slot(rr_ptr[b], k)][LB-1:0] == LB'(b)) begin
          gnt[b] = 1'b1;
          win[b] = slot(rr_ptr[b], k);
        end
    end
  end
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < RR; i++)
      bus.req_ready[i] = !RST && gnt[bus.req_PR[i][LB-1:0]] && win[bus.req_PR[i][LB-1:0]] == LRR'(i);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < BC; b++) rr_ptr[b] <= '0;
      bus.prf_bank_read_valid <= '0;
      bus.prf_bank_read_upper_PR <= '0;
      bus.prf_bank_read_req_idx <= '0;
    end else begin
      for (int b = 0; b < BC; b++) begin
        bus.prf_bank_read_valid[b] <= gnt[b];
        if (gnt[b]) begin
          rr_ptr[b] <= win[b] == LRR'(RR - 1) ? '0 : win[b] + 1'b1;
          bus.prf_bank_read_upper_PR[b] <= bus.req_PR[win[b]][LPR-1:LB];
          bus.prf_bank_read_req_idx[b] <= win[b];
        end
      end
    end
  end
endmodule

// File: tb/tb_prf_read_arbiter.sv
// tb_prf_read_arbiter: scoreboard bench for prf_read_arbiter
module tb_prf_read_arbiter;
  localparam int RR = 11, BC = 4, LPR = 7, LB = 2, LRR = 4, LU = 5;
  logic CLK = 1'b0, RST = 1'b1;
  prf_read_arbiter_if bus ();
  prf_read_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [BC-1:0] v;
    logic [BC-1:0][LU-1:0] up;
    logic [BC-1:0][LRR-1:0] idx;
  } out_t;
  out_t sb[$];
  out_t m_out;
  int m_ptr[BC];
  int m_win[BC];
  logic [RR-1:0] m_ready;
  int tests = 0, fails = 0;
  task automatic model_reset;
    for (int b = 0; b < BC; b++) m_ptr[b] = 0;
    m_out = '0;
    m_ready = '0;
  endtask
  task automatic model_eval;
    int i;
    m_ready = '0;
    for (int b = 0; b < BC; b++) begin
      m_win[b] = -1;
      if (!bus.bank_busy[b])
        for (int k = 0; k < RR; k++) begin
          i = (m_ptr[b] + k) % RR;
          if (m_win[b] < 0 && bus.req_valid[i] && bus.req_PR[i][LB-1:0] == LB'(b)) m_win[b] = i;
        end
      if (m_win[b] >= 0) m_ready[m_win[b]] = 1'b1;
    end
  endtask
  // one arbitration cycle: ready checked mid-cycle, registered outputs checked after the edge
  task automatic step;
    out_t e;
    @(negedge CLK);
    model_eval();
    tests++;
    if (bus.req_ready !== m_ready) begin
      fails++;
      $display("FAIL ready: got %b want %b", bus.req_ready, m_ready);
    end
    for (int b = 0; b < BC; b++) begin
      m_out.v[b] = m_win[b] >= 0;
      if (m_win[b] >= 0) begin
        m_out.up[b] = bus.req_PR[m_win[b]][LPR-1:LB];
        m_out.idx[b] = LRR'(m_win[b]);
        m_ptr[b] = (m_win[b] + 1) % RR;
      end
    end
    sb.push_back(m_out);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    tests += 3;
    if (bus.prf_bank_read_valid !== e.v) begin
      fails++;
      $display("FAIL bank_valid: got %b want %b", bus.prf_bank_read_valid, e.v);
    end
    if (bus.prf_bank_read_upper_PR !== e.up) begin
      fails++;
      $display("FAIL upper_PR: got %h want %h", bus.prf_bank_read_upper_PR, e.up);
    end
    if (bus.prf_bank_read_req_idx !== e.idx) begin
      fails++;
      $display("FAIL req_idx: got %h want %h", bus.prf_bank_read_req_idx, e.idx);
    end
  endtask
  task automatic do_reset;
    bus.req_valid = '0;
    bus.bank_busy = '0;
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask
  task automatic test_reset;
    bus.req_valid = '1;
    bus.bank_busy = '0;
    for (int i = 0; i < RR; i++) bus.req_PR[i] = LPR'(i);
    @(posedge CLK);
    #1;
    tests += 4;
    if (bus.req_ready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0", bus.req_ready);
    end
    if (bus.prf_bank_read_valid !== '0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", bus.prf_bank_read_valid);
    end
    if (bus.prf_bank_read_upper_PR !== '0) begin
      fails++;
      $display("FAIL reset_upper: got %h want 0", bus.prf_bank_read_upper_PR);
    end
    if (bus.prf_bank_read_req_idx !== '0) begin
      fails++;
      $display("FAIL reset_idx: got %h want 0", bus.prf_bank_read_req_idx);
    end
    model_reset();
    RST = 1'b0;
    step();
    tests++;
    if (bus.prf_bank_read_req_idx !== {4'd3, 4'd2, 4'd1, 4'd0}) begin
      fails++;
      $display("FAIL reset_first_grants: got %h want 3210", bus.prf_bank_read_req_idx);
    end
  endtask
  task automatic test_single;
    do_reset();
    bus.req_valid[5] = 1'b1;
    bus.req_PR[5] = 7'h2D;
    #2;
    tests++;
    if (bus.req_ready !== 11'b000_0010_0000) begin
      fails++;
      $display("FAIL single_ready: got %b want 00000100000", bus.req_ready);
    end
    step();
    tests += 3;
    if (bus.prf_bank_read_valid !== 4'b0010) begin
      fails++;
      $display("FAIL single_valid: got %b want 0010", bus.prf_bank_read_valid);
    end
    if (bus.prf_bank_read_upper_PR[1] !== 5'h0B) begin
      fails++;
      $display("FAIL single_upper: got %h want 0b", bus.prf_bank_read_upper_PR[1]);
    end
    if (bus.prf_bank_read_req_idx[1] !== 4'd5) begin
      fails++;
      $display("FAIL single_idx: got %0d want 5", bus.prf_bank_read_req_idx[1]);
    end
    // pointer now 6: requester 6 beats 5 on the same bank
    bus.req_valid[6] = 1'b1;
    bus.req_PR[6] = 7'h01;
    #2;
    tests++;
    if (bus.req_ready !== 11'b000_0100_0000) begin
      fails++;
      $display("FAIL single_ptr6: got %b want 00001000000", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
  endtask
  task automatic test_conflict;
    int gi[3] = '{0, 3, 7};
    do_reset();
    bus.req_valid[0] = 1'b1; bus.req_PR[0] = 7'd2;
    bus.req_valid[3] = 1'b1; bus.req_PR[3] = 7'd6;
    bus.req_valid[7] = 1'b1; bus.req_PR[7] = 7'd10;
    for (int j = 0; j < 3; j++) begin
      step();
      tests += 2;
      if (bus.prf_bank_read_req_idx[2] !== LRR'(gi[j])) begin
        fails++;
        $display("FAIL conflict_idx%0d: got %0d want %0d", j, bus.prf_bank_read_req_idx[2], gi[j]);
      end
      if (bus.prf_bank_read_upper_PR[2] !== LU'(j)) begin
        fails++;
        $display("FAIL conflict_upper%0d: got %0d want %0d", j, bus.prf_bank_read_upper_PR[2], j);
      end
      bus.req_valid[gi[j]] = 1'b0;
    end
  endtask
  task automatic test_wrap;
    do_reset();
    bus.req_valid[9] = 1'b1; bus.req_PR[9] = 7'h24;
    step();
    bus.req_valid[9] = 1'b0;
    bus.req_valid[10] = 1'b1; bus.req_PR[10] = 7'd4;
    bus.req_valid[1] = 1'b1; bus.req_PR[1] = 7'd8;
    step();
    tests++;
    if (bus.prf_bank_read_req_idx[0] !== 4'd10) begin
      fails++;
      $display("FAIL wrap_10: got %0d want 10", bus.prf_bank_read_req_idx[0]);
    end
    bus.req_valid[10] = 1'b0;
    step();
    tests++;
    if (bus.prf_bank_read_req_idx[0] !== 4'd1) begin
      fails++;
      $display("FAIL wrap_1: got %0d want 1", bus.prf_bank_read_req_idx[0]);
    end
    // pointer now 2: requester 2 beats 1
    bus.req_valid[2] = 1'b1; bus.req_PR[2] = 7'd12;
    step();
    tests++;
    if (bus.prf_bank_read_req_idx[0] !== 4'd2) begin
      fails++;
      $display("FAIL wrap_ptr2: got %0d want 2", bus.prf_bank_read_req_idx[0]);
    end
    bus.req_valid = '0;
  endtask
  task automatic test_busy;
    do_reset();
    bus.req_valid[4] = 1'b1; bus.req_PR[4] = 7'd7;
    bus.bank_busy[3] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #2;
      tests++;
      if (bus.req_ready[4] !== 1'b0) begin
        fails++;
        $display("FAIL busy_ready%0d: got %b want 0", j, bus.req_ready[4]);
      end
      step();
      tests++;
      if (bus.prf_bank_read_valid[3] !== 1'b0) begin
        fails++;
        $display("FAIL busy_valid%0d: got %b want 0", j, bus.prf_bank_read_valid[3]);
      end
    end
    bus.bank_busy[3] = 1'b0;
    step();
    tests += 2;
    if (bus.prf_bank_read_valid[3] !== 1'b1) begin
      fails++;
      $display("FAIL busy_release_valid: got %b want 1", bus.prf_bank_read_valid[3]);
    end
    if (bus.prf_bank_read_req_idx[3] !== 4'd4 || bus.prf_bank_read_upper_PR[3] !== 5'd1) begin
      fails++;
      $display("FAIL busy_release_data: got idx %0d upper %0d want idx 4 upper 1",
               bus.prf_bank_read_req_idx[3], bus.prf_bank_read_upper_PR[3]);
    end
    bus.req_valid = '0;
  endtask
  task automatic test_parallel;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_PR[i] = LPR'(i);
    end
    step();
    tests += 2;
    if (bus.prf_bank_read_valid !== 4'b1111) begin
      fails++;
      $display("FAIL par_valid: got %b want 1111", bus.prf_bank_read_valid);
    end
    if (bus.prf_bank_read_req_idx !== {4'd3, 4'd2, 4'd1, 4'd0}) begin
      fails++;
      $display("FAIL par_idx: got %h want 3210", bus.prf_bank_read_req_idx);
    end
    #2;
    RST = 1'b1;
    #1;
    tests += 2;
    if (bus.prf_bank_read_valid !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_valid: got %b want 0000", bus.prf_bank_read_valid);
    end
    if (bus.req_ready !== '0) begin
      fails++;
      $display("FAIL midrst_ready: got %b want 0", bus.req_ready);
    end
    model_reset();
    @(posedge CLK);
    #1;
    tests++;
    if (bus.prf_bank_read_valid !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_edge: got %b want 0000", bus.prf_bank_read_valid);
    end
    RST = 1'b0;
    // pointer back at 0: requester 0 beats 4 on bank 0
    bus.req_valid = '0;
    bus.req_valid[0] = 1'b1; bus.req_PR[0] = 7'd0;
    bus.req_valid[4] = 1'b1; bus.req_PR[4] = 7'd4;
    step();
    tests++;
    if (bus.prf_bank_read_req_idx[0] !== 4'd0) begin
      fails++;
      $display("FAIL midrst_ptr: got %0d want 0", bus.prf_bank_read_req_idx[0]);
    end
    bus.req_valid = '0;
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      bus.bank_busy = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < RR; i++)
        if (!bus.req_valid[i] || m_ready[i]) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          bus.req_PR[i] = LPR'($urandom);
        end
      step();
    end
    bus.req_valid = '0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_PR = '0;
    bus.bank_busy = '0;
    model_reset();
    test_reset();
    test_single();
    test_conflict();
    test_wrap();
    test_busy();
    test_parallel();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
